// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types for the two-master AXI-Lite arbiter: FSM state encoding,
// AXI response codes and the per-master request qualifier.
package ysyx_24100006_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_UART_ERR = 2'b01;  // UART answers reads with this code
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  // A write only counts as a request once both address and data are offered.
  function automatic logic is_req(input logic arvalid, input logic awvalid, input logic wvalid);
    return arvalid | (awvalid & wvalid);
  endfunction

endpackage

// File: rtl/ysyx_24100006_rr_arb2.sv
// Two-way tie-break: a sole requester wins; on a tie the master that was
// not granted last wins. Purely combinational, one-hot grant.
module ysyx_24100006_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_axi_arb2.sv
// Two-master (IFU = m0, LSU = m1) to one-slave AXI-Lite arbiter, one transaction at a time.
// Define YSYX_24100006_ARB_FIXED_PRIO_EN to make m1 win every tie instead of round-robin.
module ysyx_24100006_axi_arb2
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // master 0 (IFU)
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1 (LSU)
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // downstream slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       arb_last;
  logic [1:0] req, grant;
  logic       sel_rd0, sel_rd1, sel_wr0, sel_wr1, done;

  assign req = {is_req(m1_arvalid, m1_awvalid, m1_wvalid),
                is_req(m0_arvalid, m0_awvalid, m0_wvalid)};

  ysyx_24100006_rr_arb2 u_tie_break (
    .req_i   (req),
    .last_i  (arb_last),
    .grant_o (grant)
  );

  // Forwarding selects; in IDLE all are 0, so every output collapses to 0.
  assign sel_rd0 = (state_q == RD) & ~owner_q;
  assign sel_rd1 = (state_q == RD) &  owner_q;
  assign sel_wr0 = (state_q == WR) & ~owner_q;
  assign sel_wr1 = (state_q == WR) &  owner_q;

  assign s_araddr   = sel_rd1 ? m1_araddr : (sel_rd0 ? m0_araddr : '0);
  assign s_arvalid  = (sel_rd0 & m0_arvalid) | (sel_rd1 & m1_arvalid);
  assign s_rready   = (sel_rd0 & m0_rready)  | (sel_rd1 & m1_rready);
  assign s_awaddr   = sel_wr1 ? m1_awaddr : (sel_wr0 ? m0_awaddr : '0);
  assign s_awvalid  = (sel_wr0 & m0_awvalid) | (sel_wr1 & m1_awvalid);
  assign s_wdata    = sel_wr1 ? m1_wdata  : (sel_wr0 ? m0_wdata  : '0);
  assign s_wstrb    = sel_wr1 ? m1_wstrb  : (sel_wr0 ? m0_wstrb  : '0);
  assign s_wvalid   = (sel_wr0 & m0_wvalid)  | (sel_wr1 & m1_wvalid);
  assign s_bready   = (sel_wr0 & m0_bready)  | (sel_wr1 & m1_bready);

  assign m0_arready = sel_rd0 & s_arready;
  assign m0_rdata   = sel_rd0 ? s_rdata : '0;
  assign m0_rresp   = sel_rd0 ? s_rresp : 2'b00;
  assign m0_rvalid  = sel_rd0 & s_rvalid;
  assign m0_awready = sel_wr0 & s_awready;
  assign m0_wready  = sel_wr0 & s_wready;
  assign m0_bresp   = sel_wr0 ? s_bresp : 2'b00;
  assign m0_bvalid  = sel_wr0 & s_bvalid;

  assign m1_arready = sel_rd1 & s_arready;
  assign m1_rdata   = sel_rd1 ? s_rdata : '0;
  assign m1_rresp   = sel_rd1 ? s_rresp : 2'b00;
  assign m1_rvalid  = sel_rd1 & s_rvalid;
  assign m1_awready = sel_wr1 & s_awready;
  assign m1_wready  = sel_wr1 & s_wready;
  assign m1_bresp   = sel_wr1 ? s_bresp : 2'b00;
  assign m1_bvalid  = sel_wr1 & s_bvalid;

  assign done = ((state_q == RD) & s_rvalid & s_rready) |
                ((state_q == WR) & s_bvalid & s_bready);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: if (|grant) begin
        owner_d = grant[1];
        // A master offering both a read and a write is served its read first.
        state_d = (grant[1] ? m1_arvalid : m0_arvalid) ? RD : WR;
      end
      RD, WR:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

`ifdef YSYX_24100006_ARB_FIXED_PRIO_EN
  assign arb_last = 1'b0;  // pretend m0 went last, so m1 always takes a tie
`else
  logic last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    last_q <= 1'b1;
    else if (done) last_q <= owner_q;
  end

  assign arb_last = last_q;
`endif

endmodule

// File: tb/tb_ysyx_24100006_axi_arb2.sv
// Directed self-checking bench for ysyx_24100006_axi_arb2; the slave side is
// driven step by step by the bench, expectations are hand-computed constants.
module tb_ysyx_24100006_axi_arb2;

`ifdef YSYX_24100006_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready, m0_awvalid, m1_awvalid;
  logic        m0_wvalid, m1_wvalid, m0_bready, m1_bready;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_awready, m1_awready;
  logic        m0_wready, m1_wready, m0_bvalid, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;

  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_24100006_axi_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  function automatic bit outs_zero();
    return ({m0_arready, m0_rdata, m0_rresp, m0_rvalid, m0_awready, m0_wready, m0_bresp, m0_bvalid,
             m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid,
             s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
             s_bready} == '0);
  endfunction

  task automatic idle_bus();
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 1; m0_awaddr = '0; m0_awvalid = 0;
    m0_wdata  = '0; m0_wstrb = '0; m0_wvalid = 0; m0_bready = 1;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 1; m1_awaddr = '0; m1_awvalid = 0;
    m1_wdata  = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 1;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  // Acts as the slave for one read; reports who got arready, latency in cycles
  // and what reached the owner's r channel (x if routing was wrong).
  task automatic serve_read(input bit drop, input logic [31:0] data, input logic [1:0] resp,
                            output int who, output int lat, output logic [31:0] addr,
                            output logic [31:0] rdata, output logic [1:0] rresp,
                            output bit idle_after);
    who = -1; lat = 0; addr = '0; rdata = 'x; rresp = 'x; idle_after = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk); #1;
      if (s_arvalid) lat = i;
    end
    if (lat == 0) return;
    addr = s_araddr;
    s_arready = 1; #1;
    if (m0_arready && !m1_arready) who = 0;
    else if (m1_arready && !m0_arready) who = 1;
    @(negedge clk);
    s_arready = 0;
    if (drop && who == 0) m0_arvalid = 0;
    if (drop && who == 1) m1_arvalid = 0;
    s_rvalid = 1; s_rdata = data; s_rresp = resp; #1;
    if (who == 0 && m0_rvalid && !m1_rvalid && m1_rdata == 0) begin rdata = m0_rdata; rresp = m0_rresp; end
    if (who == 1 && m1_rvalid && !m0_rvalid && m0_rdata == 0) begin rdata = m1_rdata; rresp = m1_rresp; end
    @(negedge clk);
    s_rvalid = 0; s_rdata = '0; s_rresp = '0; #1;
    idle_after = !s_arvalid && !s_awvalid && !s_wvalid;
  endtask

  task automatic serve_write(input bit drop, input logic [1:0] resp,
                             output int who, output int lat, output logic [31:0] addr,
                             output logic [31:0] wdata, output logic [3:0] wstrb,
                             output logic [1:0] bresp, output bit idle_after);
    who = -1; lat = 0; addr = '0; wdata = '0; wstrb = '0; bresp = 'x; idle_after = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk); #1;
      if (s_awvalid && s_wvalid) lat = i;
    end
    if (lat == 0) return;
    addr = s_awaddr; wdata = s_wdata; wstrb = s_wstrb;
    s_awready = 1; s_wready = 1; #1;
    if (m0_awready && m0_wready && !m1_awready && !m1_wready) who = 0;
    else if (m1_awready && m1_wready && !m0_awready && !m0_wready) who = 1;
    @(negedge clk);
    s_awready = 0; s_wready = 0;
    if (drop && who == 0) begin m0_awvalid = 0; m0_wvalid = 0; end
    if (drop && who == 1) begin m1_awvalid = 0; m1_wvalid = 0; end
    s_bvalid = 1; s_bresp = resp; #1;
    if (who == 0 && m0_bvalid && !m1_bvalid && m1_bresp == 0) bresp = m0_bresp;
    if (who == 1 && m1_bvalid && !m0_bvalid && m0_bresp == 0) bresp = m1_bresp;
    @(negedge clk);
    s_bvalid = 0; s_bresp = '0; #1;
    idle_after = !s_arvalid && !s_awvalid && !s_wvalid;
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 0;
    m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'hdead_beef; s_rresp = 2'b01;
    s_bvalid = 1; s_bresp = 2'b10; s_awready = 1; s_wready = 1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL reset_outs_zero: got %b expected 1", outs_zero()); end
    idle_bus();
    @(negedge clk);
    reset = 1;
    @(negedge clk); #1;
    n_vec++;
    if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL idle_outs_zero: got %b expected 1", outs_zero()); end
  endtask

  task automatic test_tie_after_reset();
    int who, lat; logic [31:0] addr, rd; logic [1:0] rr; bit idl;
    int first, second;
    first  = FIXED ? 1 : 0;
    second = FIXED ? 0 : 1;
    @(negedge clk);
    m0_araddr = 32'h8000_0000; m0_arvalid = 1;
    m1_araddr = 32'h8000_0100; m1_arvalid = 1;
    serve_read(1'b1, 32'h1111_1111, 2'b00, who, lat, addr, rd, rr, idl);
    n_vec++; if (who !== first) begin n_err++; $display("FAIL tie_first_owner: got %0d expected %0d", who, first); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL tie_first_latency: got %0d expected 1", lat); end
    n_vec++; if (rd !== 32'h1111_1111) begin n_err++; $display("FAIL tie_first_rdata: got %h expected 11111111", rd); end
    n_vec++; if (idl !== 1'b1) begin n_err++; $display("FAIL tie_idle_gap: got %b expected 1", idl); end
    serve_read(1'b1, 32'h2222_2222, 2'b00, who, lat, addr, rd, rr, idl);
    n_vec++; if (who !== second) begin n_err++; $display("FAIL tie_second_owner: got %0d expected %0d", who, second); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL tie_second_latency: got %0d expected 1", lat); end
    n_vec++;
    if (addr !== (FIXED ? 32'h8000_0000 : 32'h8000_0100)) begin
      n_err++; $display("FAIL tie_second_addr: got %h expected %h", addr, FIXED ? 32'h8000_0000 : 32'h8000_0100);
    end
    n_vec++; if (rd !== 32'h2222_2222) begin n_err++; $display("FAIL tie_second_rdata: got %h expected 22222222", rd); end
  endtask

  task automatic test_single_write();
    int who, lat; logic [31:0] addr, wd; logic [3:0] ws; logic [1:0] br; bit idl;
    @(negedge clk);
    m1_awaddr = 32'ha000_03f8; m1_wdata = 32'h0000_0041; m1_wstrb = 4'b0001;
    m1_awvalid = 1; m1_wvalid = 1; #1;
    n_vec++; if (s_awvalid !== 1'b0) begin n_err++; $display("FAIL wr_same_cycle_awvalid: got %b expected 0", s_awvalid); end
    serve_write(1'b1, 2'b00, who, lat, addr, wd, ws, br, idl);
    n_vec++; if (who !== 1) begin n_err++; $display("FAIL wr_owner: got %0d expected 1", who); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL wr_latency: got %0d expected 1", lat); end
    n_vec++; if (addr !== 32'ha000_03f8) begin n_err++; $display("FAIL wr_awaddr: got %h expected a00003f8", addr); end
    n_vec++; if (wd !== 32'h41) begin n_err++; $display("FAIL wr_wdata: got %h expected 00000041", wd); end
    n_vec++; if (ws !== 4'b0001) begin n_err++; $display("FAIL wr_wstrb: got %b expected 0001", ws); end
    n_vec++; if (br !== 2'b00) begin n_err++; $display("FAIL wr_bresp: got %b expected 00", br); end
    n_vec++; if (idl !== 1'b1) begin n_err++; $display("FAIL wr_back_to_idle: got %b expected 1", idl); end
    @(negedge clk); #1;
    n_vec++; if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL wr_no_regrant: got %b expected 1", outs_zero()); end
  endtask

  task automatic test_round_robin();
    int who, lat; logic [31:0] addr, rd; logic [1:0] rr; bit idl;
    int exp_who [4] = FIXED ? '{1, 1, 1, 1} : '{0, 1, 0, 1};
    @(negedge clk);
    m0_araddr = 32'h3000_0000; m0_arvalid = 1;
    m1_araddr = 32'h3000_1000; m1_arvalid = 1;
    for (int k = 0; k < 4; k++) begin
      serve_read(1'b0, 32'h5000_0000 + k, 2'b00, who, lat, addr, rd, rr, idl);
      n_vec++;
      if (who !== exp_who[k]) begin n_err++; $display("FAIL rr_owner_%0d: got %0d expected %0d", k, who, exp_who[k]); end
      n_vec++;
      if (lat !== 1) begin n_err++; $display("FAIL rr_latency_%0d: got %0d expected 1", k, lat); end
      n_vec++;
      if (rd !== 32'h5000_0000 + k) begin n_err++; $display("FAIL rr_rdata_%0d: got %h expected %h", k, rd, 32'h5000_0000 + k); end
    end
    m0_arvalid = 0; m1_arvalid = 0;
    @(negedge clk); #1;
    n_vec++; if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL rr_drained: got %b expected 1", outs_zero()); end
  endtask

  task automatic test_read_over_write();
    int who, lat; logic [31:0] addr, rd, wd; logic [3:0] ws; logic [1:0] rr, br; bit idl;
    @(negedge clk);
    m0_araddr = 32'ha000_03f8; m0_arvalid = 1;
    m0_awaddr = 32'h8000_0040; m0_wdata = 32'hcafe_f00d; m0_wstrb = 4'hf;
    m0_awvalid = 1; m0_wvalid = 1;
    serve_read(1'b1, 32'h0, 2'b01, who, lat, addr, rd, rr, idl);
    n_vec++; if (who !== 0) begin n_err++; $display("FAIL rw_read_owner: got %0d expected 0", who); end
    n_vec++; if (addr !== 32'ha000_03f8) begin n_err++; $display("FAIL rw_read_addr: got %h expected a00003f8", addr); end
    n_vec++; if (rr !== 2'b01) begin n_err++; $display("FAIL rw_rresp: got %b expected 01", rr); end
    serve_write(1'b1, 2'b10, who, lat, addr, wd, ws, br, idl);
    n_vec++; if (who !== 0) begin n_err++; $display("FAIL rw_write_owner: got %0d expected 0", who); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL rw_write_latency: got %0d expected 1", lat); end
    n_vec++; if (wd !== 32'hcafe_f00d) begin n_err++; $display("FAIL rw_wdata: got %h expected cafef00d", wd); end
    n_vec++; if (br !== 2'b10) begin n_err++; $display("FAIL rw_bresp: got %b expected 10", br); end
  endtask

  task automatic test_reset_mid_write();
    int who, lat; logic [31:0] addr, rd; logic [1:0] rr; bit idl;
    @(negedge clk);
    m1_awaddr = 32'ha000_03f8; m1_wdata = 32'h42; m1_wstrb = 4'b0001;
    m1_awvalid = 1; m1_wvalid = 1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk); #1;
      if (s_awvalid && s_wvalid) lat = i;
    end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL mid_wr_latency: got %0d expected 1", lat); end
    s_awready = 1; s_wready = 1;
    @(negedge clk);
    s_awready = 0; s_wready = 0; #1;
    n_vec++; if (s_awvalid !== 1'b1) begin n_err++; $display("FAIL mid_wr_still_owned: got %b expected 1", s_awvalid); end
    reset = 0; #1;
    n_vec++; if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL mid_wr_async_zero: got %b expected 1", outs_zero()); end
    s_bvalid = 1; s_bresp = 2'b10; #1;
    n_vec++; if (m1_bvalid !== 1'b0) begin n_err++; $display("FAIL mid_wr_no_bvalid: got %b expected 0", m1_bvalid); end
    @(negedge clk);
    s_bvalid = 0; s_bresp = '0; m1_awvalid = 0; m1_wvalid = 0;
    reset = 1;
    @(negedge clk); #1;
    n_vec++; if (outs_zero() !== 1'b1) begin n_err++; $display("FAIL mid_wr_idle_after: got %b expected 1", outs_zero()); end
    m0_araddr = 32'h8000_0200; m0_arvalid = 1;
    m1_araddr = 32'h8000_0300; m1_arvalid = 1;
    serve_read(1'b1, 32'h7777_0000, 2'b00, who, lat, addr, rd, rr, idl);
    n_vec++;
    if (who !== (FIXED ? 1 : 0)) begin n_err++; $display("FAIL mid_wr_tie_owner: got %0d expected %0d", who, FIXED ? 1 : 0); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL mid_wr_tie_latency: got %0d expected 1", lat); end
    serve_read(1'b1, 32'h7777_0001, 2'b00, who, lat, addr, rd, rr, idl);
    n_vec++;
    if (who !== (FIXED ? 0 : 1)) begin n_err++; $display("FAIL mid_wr_second_owner: got %0d expected %0d", who, FIXED ? 0 : 1); end
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_single_write();
    test_round_robin();
    test_read_over_write();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/ysyx_24100006_axi_arb2.md
YSYX_24100006_AXI_ARB2 -- requirements
Module: ysyx_24100006_axi_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ar/aw channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all r/w channels (wstrb width DATA_W/8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have ports mN_araddr/mN_arvalid in and mN_arready out, 32/1/1, read-address channel of upstream master N (N = 0 IFU, N = 1 LSU).
REQ-006 SHALL have ports mN_rdata/mN_rresp/mN_rvalid out and mN_rready in, 32/2/1/1, read-data channel of master N.
REQ-007 SHALL have ports mN_awaddr/mN_awvalid in and mN_awready out, 32/1/1, write-address channel of master N.
REQ-008 SHALL have ports mN_wdata/mN_wstrb/mN_wvalid in and mN_wready out, 32/4/1/1, write-data channel of master N.
REQ-009 SHALL have ports mN_bresp/mN_bvalid out and mN_bready in, 2/1/1, write-response channel of master N.
REQ-010 SHALL have ports s_* with the same five channels and mirrored directions toward the single downstream AXI-Lite slave (UART/memory).

Function
REQ-011 SHALL define request of master N as mN_arvalid | (mN_awvalid & mN_wvalid).
REQ-012 SHALL implement FSM states IDLE, RD, WR plus a registered owner bit and a last-granted pointer.
REQ-013 SHALL in IDLE grant, on the clock edge, one requesting master: sole requester wins; on a tie, the master not equal to the last-granted pointer wins.
REQ-014 SHALL, for the granted master, enter RD if its arvalid is 1, else WR (read wins over simultaneous write from one master).
REQ-015 SHALL in RD combinationally forward owner ar to s_ar and s_r to owner r; in WR forward owner aw, w to s_aw, s_w and s_b to owner b.
REQ-016 SHALL hold every ready/valid toward the non-owner at 0, and all s_*valid at 0 in IDLE; mN_rdata/rresp/bresp SHALL be 0 when not forwarded.
REQ-017 SHALL leave RD on s_rvalid & owner rready, and WR on s_bvalid & owner bready, returning to IDLE and setting last-granted to owner in the same edge.
REQ-018 SHALL impose exactly one IDLE cycle between consecutive grants; first forwarded valid appears one cycle after request.
REQ-019 SHALL pass rresp/bresp unchanged (including 01 from the UART on reads).
REQ-020 SHALL keep ownership if the owner drops valid mid-transaction (protocol violation, no timeout).

Reset
REQ-021 SHALL, while reset=0, force state IDLE, owner 0, last-granted 1 (master 0 wins first tie), all outputs 0, asynchronously.
REQ-022 SHALL on reset mid-transaction abandon it; outstanding slave response is not replayed.

Configuration
REQ-023 SHALL honour macro YSYX_24100006_ARB_FIXED_PRIO_EN: defined -> master 1 always wins ties and the pointer is unused; undefined -> round-robin of REQ-013.

Structure
REQ-024 SHALL place state enum (IDLE/RD/WR) and response codes (OKAY 00, UART-unreadable 01, SLVERR 10) in package ysyx_24100006_axi_pkg.
REQ-025 SHALL implement tie-break in sub-module ysyx_24100006_rr_arb2 (req[1:0], pointer in, one-hot grant out).

Verification
REQ-026 SHALL cover: m1 write awaddr=a00003f8 wdata=0x41 alone -> s_awvalid/s_wvalid 1 cycle later, m1_bvalid with bresp 00, return to IDLE.
REQ-027 SHALL cover: m0 and m1 arvalid same cycle after reset -> m0 served first, m1 second, one IDLE cycle between.
REQ-028 SHALL cover: both request continuously over 4 transactions -> grants alternate 0,1,0,1 (fixed-prio build: 1,1,1,1).
REQ-029 SHALL cover: m0 arvalid and awvalid+wvalid together -> read completes (rresp 01 from UART), write next grant.
REQ-030 SHALL cover: reset=0 asserted while in WR before bvalid -> all outputs 0 immediately, IDLE after release.
